alarm_controller: RTL and testbench

Single-clock sequencer for the alarm function. It arms and disarms the alarm and detects the alarm-time match. It runs the ring timeout and the snooze cycle, and it generates the beep tone and the display-blank pattern. It sits between the time/alarm comparators (which supply `match`) and the display/buzzer drivers. One-second timing comes from a 1 Hz tick strobe in the `clk_fast` domain.

---
 rtl/alarm_controller_if.sv | 25 ++
 rtl/alarm_controller.sv | 122 ++++++++++++
 tb/tb_alarm_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm sequencer and its surroundings.
interface alarm_controller_if;
  // en and match are levels; tick_1hz, snooze and dismiss are one-cycle strobes
  // that are acted on in the cycle they are high, with no acknowledge.
  logic       en;
  logic       match;
  logic       tick_1hz;
  logic       snooze;
  logic       dismiss;
  logic [1:0] state;
  logic       ringing;
  logic       snooze_active;
  logic       beep;
  logic       output_blank;

  modport master (
    output en, match, tick_1hz, snooze, dismiss,
    input  state, ringing, snooze_active, beep, output_blank
  );

  modport slave (
    input  en, match, tick_1hz, snooze, dismiss,
    output state, ringing, snooze_active, beep, output_blank
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: arm/disarm, match-edge trigger, ring timeout, snooze cycle,
// beep tone and blink pattern for the display.
module alarm_controller #(
  parameter int RING_SECONDS   = 300,
  parameter int SNOOZE_SECONDS = 540,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 16
) (
  input  logic              clk_fast,
  input  logic              reset,
  alarm_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [1:0]    state_q, state_d;
  logic [11:0]   timer_q, timer_d;
  logic          gate_q, gate_d;
  logic [2:0]    snz_q, snz_d;
  logic          match_d;
  logic          trig;
  logic          tone_q;
  logic [TW-1:0] tone_cnt_q;

  assign trig = bus.match & ~match_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gate_d  = gate_q;
    snz_d   = snz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (trig) begin
          state_d = S_RINGING;
          timer_d = 12'(RING_SECONDS);
          gate_d  = 1'b1;
          snz_d   = 3'd0;
        end
      end
      S_RINGING: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (bus.dismiss) begin
          state_d = S_ARMED;
        end else if (bus.snooze && (snz_q < 3'(MAX_SNOOZE))) begin
          state_d = S_SNOOZE;
          timer_d = 12'(SNOOZE_SECONDS);
          snz_d   = snz_q + 3'd1;
        end else if (bus.tick_1hz) begin
          if (timer_q == 12'd1) begin
            state_d = S_ARMED;
          end else begin
            timer_d = timer_q - 12'd1;
            gate_d  = ~gate_q;
          end
        end
      end
      default: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (bus.dismiss) begin
          state_d = S_ARMED;
        end else if (bus.tick_1hz) begin
          if (timer_q == 12'd1) begin
            state_d = S_RINGING;
            timer_d = 12'(RING_SECONDS);
            gate_d  = 1'b1;
          end else begin
            timer_d = timer_q - 12'd1;
          end
        end
      end
    endcase
  end

  // match_d resets high so a reset inside the match minute cannot produce an edge.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= 12'd0;
      gate_q  <= 1'b0;
      snz_q   <= 3'd0;
      match_d <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gate_q  <= gate_d;
      snz_q   <= snz_d;
      match_d <= bus.match;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (reset || (state_q != S_RINGING)) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TW'(TONE_DIV - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  assign bus.state         = state_q;
  assign bus.ringing       = (state_q == S_RINGING);
  assign bus.snooze_active = (state_q == S_SNOOZE);
  assign bus.beep          = (state_q == S_RINGING) & gate_q & tone_q;
  assign bus.output_blank  = ~((state_q == S_RINGING) & ~gate_q);

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random traffic, checked
// every cycle against a seconds-level behavioural model.
module tb_alarm_controller;
  localparam int RING = 5;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;
  localparam int TDIV = 2;

  logic clk_fast = 1'b0;
  logic reset    = 1'b1;

  alarm_controller_if bus();

  alarm_controller #(
    .RING_SECONDS  (RING),
    .SNOOZE_SECONDS(SNZ),
    .MAX_SNOOZE    (MAXS),
    .TONE_DIV      (TDIV)
  ) dut (
    .clk_fast(clk_fast),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_fast = ~clk_fast;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: mode, seconds left, seconds elapsed in this ring, cycles spent ringing.
  int m_st = 0, m_left = 0, m_elapsed = 0, m_ring_cyc = 0, m_snz = 0;
  bit m_prev  = 1'b1;
  bit m_valid = 1'b0;

  always @(posedge clk_fast) begin
    int  old_st;
    bit  edge_seen;
    if (reset) begin
      m_st = 0; m_left = 0; m_elapsed = 0; m_ring_cyc = 0; m_snz = 0;
      m_prev = 1'b1; m_valid = 1'b1;
    end else begin
      edge_seen = bus.match && !m_prev;
      m_prev    = bus.match;
      old_st    = m_st;
      if (m_st != 0 && !bus.en) begin
        m_st = 0;
      end else if (m_st == 0) begin
        if (bus.en) m_st = 1;
      end else if (m_st == 1) begin
        if (edge_seen) begin
          m_st = 2; m_left = RING; m_elapsed = 0; m_snz = 0;
        end
      end else if (bus.dismiss) begin
        m_st = 1;
      end else if (m_st == 2 && bus.snooze && m_snz < MAXS) begin
        m_st = 3; m_left = SNZ; m_snz++;
      end else if (bus.tick_1hz) begin
        if (m_left == 1) begin
          if (m_st == 2) m_st = 1;
          else begin m_st = 2; m_left = RING; m_elapsed = 0; end
        end else begin
          m_left--;
          if (m_st == 2) m_elapsed++;
        end
      end
      m_ring_cyc = (old_st == 2) ? m_ring_cyc + 1 : 0;
    end
  end

  function automatic logic [7:0] model_outputs();
    bit ring, gate, tone;
    ring = (m_st == 2);
    gate = (m_elapsed % 2) == 0;
    tone = ((m_ring_cyc / TDIV) % 2) == 1;
    return {2'b00, 2'(m_st), ring, (m_st == 3), ring && gate && tone, !(ring && !gate)};
  endfunction

  always @(negedge clk_fast) begin
    if (m_valid)
      check("cycle", {2'b00, bus.state, bus.ringing, bus.snooze_active, bus.beep, bus.output_blank},
            model_outputs());
  end

  task automatic drive(input logic r, e, m, t, s, d);
    reset = r; bus.en = e; bus.match = m; bus.tick_1hz = t; bus.snooze = s; bus.dismiss = d;
    @(negedge clk_fast);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, bus.en, bus.match, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sec();
    drive(1'b0, bus.en, bus.match, 1'b1, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic ring_up();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.match = 1'b0; bus.tick_1hz = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
    @(negedge clk_fast);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("reset_state", 8'(bus.state), 8'd0);
    check("reset_blank", 8'(bus.output_blank), 8'd1);
    check("reset_beep", 8'(bus.beep), 8'd0);

    // Basic ring and timeout with blink pattern
    drive(0, 1, 0, 0, 0, 0);
    check("armed", 8'(bus.state), 8'd1);
    drive(0, 1, 1, 0, 0, 0);
    check("ring_entry", 8'(bus.state), 8'd2);
    check("blank_sec0", 8'(bus.output_blank), 8'd1);
    idle(4);
    for (int i = 1; i <= 4; i++) begin
      sec();
      check("blank_pattern", 8'(bus.output_blank), 8'((i % 2) == 0));
      check("ring_hold", 8'(bus.state), 8'd2);
    end
    sec();
    check("timeout", 8'(bus.state), 8'd1);
    idle(10);
    check("no_retrig", 8'(bus.state), 8'd1);

    // Snooze twice, third snooze ignored, then timeout
    ring_up();
    drive(0, 1, 1, 0, 1, 0);
    check("snooze1", 8'(bus.state), 8'd3);
    sec(); sec();
    check("snooze_hold", 8'(bus.state), 8'd3);
    sec();
    check("rering1", 8'(bus.state), 8'd2);
    drive(0, 1, 1, 0, 1, 0);
    check("snooze2", 8'(bus.state), 8'd3);
    sec(); sec(); sec();
    check("rering2", 8'(bus.state), 8'd2);
    drive(0, 1, 1, 0, 1, 0);
    check("snooze_exhausted", 8'(bus.state), 8'd2);
    for (int i = 0; i < 4; i++) sec();
    check("reload_hold", 8'(bus.state), 8'd2);
    sec();
    check("timeout2", 8'(bus.state), 8'd1);

    // Dismiss beats snooze; dismiss on the final tick
    ring_up();
    drive(0, 1, 1, 0, 1, 1);
    check("dismiss_vs_snooze", 8'(bus.state), 8'd1);
    ring_up();
    for (int i = 0; i < 4; i++) sec();
    drive(0, 1, 1, 1, 0, 1);
    check("dismiss_last_tick", 8'(bus.state), 8'd1);

    // Disarm while ringing and while snoozing
    ring_up();
    idle(3);
    drive(0, 0, 1, 0, 0, 0);
    check("disarm_ring", 8'(bus.state), 8'd0);
    check("disarm_beep", 8'(bus.beep), 8'd0);
    check("disarm_blank", 8'(bus.output_blank), 8'd1);
    drive(0, 1, 1, 0, 0, 0);
    idle(5);
    check("rearm_no_ring", 8'(bus.state), 8'd1);
    ring_up();
    drive(0, 1, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("disarm_snooze", 8'(bus.state), 8'd0);
    drive(0, 1, 1, 0, 0, 0);

    // Reset mid-ring with match high
    ring_up();
    sec();
    drive(1, 1, 1, 0, 0, 0);
    check("rst_state", 8'(bus.state), 8'd0);
    check("rst_blank", 8'(bus.output_blank), 8'd1);
    check("rst_ringing", 8'(bus.ringing), 8'd0);
    drive(0, 1, 1, 0, 0, 0);
    idle(5);
    check("rst_no_ring", 8'(bus.state), 8'd1);
    ring_up();
    check("rst_then_edge", 8'(bus.state), 8'd2);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);

    // Tick coincident with the match edge is not consumed
    drive(0, 1, 1, 1, 0, 0);
    check("tick_on_edge", 8'(bus.state), 8'd2);
    for (int i = 0; i < 4; i++) sec();
    check("tick_edge_hold", 8'(bus.state), 8'd2);
    sec();
    check("tick_edge_timeout", 8'(bus.state), 8'd1);

    // Random traffic
    repeat (3000) begin
      logic m;
      m = bus.match;
      if ($urandom_range(0, 15) == 0) m = ~m;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0, m,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
